serial_shifter: RTL and testbench

Multi-cycle, bit-serial execution unit for shifter commands (cmd_t: NONE, SHL, SHR, ROL, ROR). It sits on the CPU datapath as the responder to the instruction decoder/issuer.
- Accepts one command plus operand and amount over a valid/ready handshake.
- Moves one bit position per clock.
- Returns the result, carry and error flags over a second valid/ready handshake.
- Trades latency for area compared with a barrel shifter.

---
 rtl/shifter_types.sv | 24 ++
 rtl/shift_step.sv | 41 ++++
 rtl/serial_shifter.sv | 90 +++++++++
 tb/tb_serial_shifter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_types.sv
// Shared types for the shifter datapath: command encoding, serial FSM states
// and the legal-command predicate.
package shifter_types;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encodings 5..7 are reserved and reported as errors.
  function automatic logic is_legal_cmd(input logic [2:0] c);
    return (c <= 3'd4);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step; pure combinational so a barrel shifter can
// chain several copies later.
module shift_step
  import shifter_types::*;
#(
  parameter int WIDTH = 8
) (
  input  cmd_t             op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             carry
);

  always_comb begin
    value_next = value;
    carry      = 1'b0;
    unique case (op)
      SHL: begin
        carry      = value[WIDTH-1];
        value_next = {value[WIDTH-2:0], 1'b0};
      end
      SHR: begin
        carry      = value[0];
        value_next = {1'b0, value[WIDTH-1:1]};
      end
      ROL: begin
        carry      = value[WIDTH-1];
        value_next = {value[WIDTH-2:0], value[WIDTH-1]};
      end
      ROR: begin
        carry      = value[0];
        value_next = {value[0], value[WIDTH-1:1]};
      end
      default: begin
        value_next = value;
        carry      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// Bit-serial shift/rotate unit: accepts a command, moves one bit per clock,
// then holds the result until the consumer takes it.
//   state | meaning
//   IDLE  | ready for a command
//   RUN   | stepping, count holds remaining steps
//   DONE  | result presented, waiting for res_ready
module serial_shifter
  import shifter_types::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err
);

  state_t           state, state_next;
  cmd_t             op;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;
  logic             skip_run;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op         (op),
    .value      (result),
    .value_next (step_value),
    .carry      (step_carry)
  );

  // NONE, reserved encodings and zero amounts complete without stepping.
  assign skip_run = (cmd == NONE) || !is_legal_cmd(cmd) || (amount == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_next = skip_run ? DONE : RUN;
      RUN:     if (count == AMT_W'(1)) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
      count  <= '0;
      op     <= NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            result <= operand;
            op     <= cmd_t'(cmd);
            count  <= amount;
            carry  <= 1'b0;
            err    <= !is_legal_cmd(cmd);
          end
        end
        RUN: begin
          result <= step_value;
          carry  <= step_carry;
          count  <= count - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);

endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter: driver pushes model results, a
// negedge monitor pops and compares whenever a result is presented.
module tb_serial_shifter;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk, rst_n;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] result;
  logic             carry, err;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       e;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   hold = 0;
  bit   force_rr = 0;

  serial_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .operand   (operand),
    .amount    (amount),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry     (carry),
    .err       (err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    res_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (hold)          res_ready = 0;
      else if (force_rr) res_ready = 1;
      else               res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-amount shifts/rotates in one arithmetic expression.
  function automatic exp_t model(input int c, input logic [7:0] op, input int amt);
    exp_t        x;
    logic [15:0] dbl;
    x.e = (c > 4);
    x.r = op;
    x.c = 0;
    x.lat = 0;
    x.acc = 0;
    if (c >= 1 && c <= 4 && amt > 0) begin
      x.lat = amt;
      dbl = {op, op};
      case (c)
        1: begin x.r = 8'(op << amt); x.c = op[8 - amt]; end
        2: begin x.r = op >> amt;     x.c = op[amt - 1]; end
        3: begin dbl = dbl << amt; x.r = dbl[15:8]; x.c = x.r[0]; end
        default: begin dbl = dbl >> amt; x.r = dbl[7:0]; x.c = x.r[7]; end
      endcase
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got result %0h with empty scoreboard", result);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", cyc - q[0].acc, q[0].lat);
        end
        check("result", result, q[0].r);
        check("carry", carry, q[0].c);
        check("err", err, q[0].e);
        check("cmd_ready_in_done", cmd_ready, 0);
        if (res_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input int c, input logic [7:0] op, input int amt);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: cmd_ready stayed 0 for %0d cycles", n);
      return;
    end
    cmd_valid = 1;
    cmd       = 3'(c);
    operand   = op;
    amount    = 3'(amt);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    x = model(c, op, amt);
    x.acc = cyc;
    q.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
      q.delete();
      seen = 0;
    end
  endtask

  initial begin
    int n;
    rst_n = 0;
    cmd_valid = 0;
    cmd = 0;
    operand = 0;
    amount = 0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;

    issue(1, 8'h81, 1);
    issue(4, 8'h01, 3);
    issue(2, 8'hF0, 5);
    issue(3, 8'hA5, 7);
    issue(0, 8'h5A, 4);
    issue(6, 8'h3C, 2);
    issue(1, 8'hC3, 0);
    drain();

    // Backpressure: result held, new commands ignored.
    hold = 1;
    issue(4, 8'h01, 3);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_done", res_valid, 1);
    repeat (10) begin
      @(negedge clk);
      #1;
      cmd_valid = 1;
      cmd       = 3'd1;
      operand   = 8'($urandom);
      amount    = 3'd2;
    end
    @(negedge clk);
    cmd_valid = 0;
    check("bp_still_valid", res_valid, 1);
    hold = 0;
    force_rr = 1;
    @(posedge clk);
    #2;
    check("bp_rr_high", res_ready, 1);
    check("bp_valid_before_release", res_valid, 1);
    @(posedge clk);
    #2;
    check("bp_idle_after_rr", cmd_ready, 1);
    check("bp_valid_dropped", res_valid, 0);
    force_rr = 0;
    drain();

    // Asynchronous reset mid-RUN.
    issue(1, 8'hFF, 7);
    repeat (3) @(posedge clk);
    #3;
    check("run_cmd_ready", cmd_ready, 0);
    rst_n = 0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_res_valid", res_valid, 0);
    check("arst_result", result, 0);
    check("arst_carry", carry, 0);
    check("arst_err", err, 0);
    q.delete();
    seen = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    issue(1, 8'hFF, 7);
    drain();

    for (int i = 0; i < 80; i++)
      issue($urandom_range(0, 7), 8'($urandom), $urandom_range(0, 7));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
